dmem_responder: RTL and testbench



---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage and the data memory.
// The requester drives the master modport; dmem_responder uses the slave modport.
interface dmem_responder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_write;
  logic [2:0]      req_size;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one request at a time, response after LATENCY cycles.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of aligning them down.
module dmem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int ADDR_BITS = $clog2(MEM_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state_reg;
  logic [3:0]      cnt_reg;
  logic [XLEN-1:0] addr_reg;
  logic            write_reg;
  logic [2:0]      size_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            rsp_valid_reg;
  logic            err_reg;
  logic [XLEN-1:0] word_q_reg;

  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic in_idle, handshake, enter_resp;
  assign in_idle       = (state_reg == IDLE);
  assign bus.req_ready = in_idle && !rst;
  assign handshake     = bus.req_valid && bus.req_ready;

  // During the handshake cycle the access decodes the live request, otherwise the latched one.
  logic [XLEN-1:0]      cur_addr, cur_wdata;
  logic                 cur_write;
  logic [2:0]           cur_size;
  logic [ADDR_BITS-1:0] cur_idx;
  assign cur_addr  = in_idle ? bus.req_addr  : addr_reg;
  assign cur_wdata = in_idle ? bus.req_wdata : wdata_reg;
  assign cur_write = in_idle ? bus.req_write : write_reg;
  assign cur_size  = in_idle ? bus.req_size  : size_reg;
  assign cur_idx   = cur_addr[ADDR_BITS+1:2];

  assign enter_resp = (handshake && (LATENCY == 1)) || ((state_reg == WAIT) && (cnt_reg == 4'd1));

  logic size_ok, bad_store, out_of_range, misalign, acc_err, do_write;
  assign size_ok      = (cur_size == 3'b000) || (cur_size == 3'b001) || (cur_size == 3'b010) ||
                        (cur_size == 3'b100) || (cur_size == 3'b101);
  assign bad_store    = cur_write && cur_size[2];
  assign out_of_range = (cur_addr >= XLEN'(4 * MEM_DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((cur_size[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_size == 3'b010) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign acc_err  = !size_ok || bad_store || out_of_range || misalign;
  assign do_write = enter_resp && cur_write && !acc_err && !rst;

  // Byte enables and lane-replicated store data; H ignores addr[0] when not trapping.
  logic [3:0]      byte_en;
  logic [XLEN-1:0] wlane;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = (cur_size[1:0] == 2'b00) ? (cur_addr[1:0] == 2'(gi)) :
                           (cur_size[1:0] == 2'b01) ? (cur_addr[1] == 1'(gi / 2)) : 1'b1;
      assign wlane[8*gi +: 8] = (cur_size[1:0] == 2'b00) ? cur_wdata[7:0] :
                                (cur_size[1:0] == 2'b01) ? cur_wdata[8*(gi%2) +: 8] :
                                                           cur_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      word_q_reg <= mem[cur_idx];
      for (int b = 0; b < 4; b++) begin
        if (do_write && byte_en[b]) mem[cur_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= 3'b000;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (handshake) begin
          addr_reg  <= bus.req_addr;
          write_reg <= bus.req_write;
          size_reg  <= bus.req_size;
          wdata_reg <= bus.req_wdata;
          cnt_reg   <= 4'(LATENCY - 1);
          state_reg <= (LATENCY > 1) ? WAIT : RESP;
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid_reg <= 1'b1;
        err_reg       <= acc_err;
      end
    end
  end

  // Load extraction from the registered word; stores and faults return zero.
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_data;
  assign sel_byte = word_q_reg[{addr_reg[1:0], 3'b000} +: 8];
  assign sel_half = addr_reg[1] ? word_q_reg[31:16] : word_q_reg[15:0];

  always_comb begin
    load_data = word_q_reg;
    case (size_reg)
      3'b000:  load_data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, sel_byte};
      3'b001:  load_data = {{(XLEN-16){sel_half[15]}}, sel_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, sel_half};
      default: load_data = word_q_reg;
    endcase
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_valid_reg && err_reg;
  assign bus.rsp_rdata = (rsp_valid_reg && !write_reg && !err_reg) ? load_data : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder (LATENCY=2, MEM_DEPTH=1024).
// Expected values follow DMEM_MISALIGN_TRAP_EN when the bench is built with it.
module tb_dmem_responder;
  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.XLEN(32)) bus ();

  dmem_responder #(
    .XLEN(32), .MEM_DEPTH(1024), .LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    drive_req(v.wr, v.size, v.addr, v.wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (!bus.rsp_valid) return;
    check({tag, " latency"}, 32'(cyc), 32'(LAT));
    check({tag, " rdata"}, bus.rsp_rdata, v.exp_rdata);
    check({tag, " err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    $display("txn %s: %s size=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
             tag, v.wr ? "ST" : "LD", v.size, v.addr, v.wdata, bus.rsp_rdata, bus.rsp_err, cyc);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, " rsp_valid cleared"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 3'b010;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // size codes: B=000 H=001 W=010 BU=100 HU=101
    vecs.push_back(mk(1, 3'b010, 32'h0000, 32'hA5A5A5A5, 32'h0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h0010, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0010, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 3'b000, 32'h0013, 32'h00000080, 32'h0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h0013, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 3'b100, 32'h0013, 32'h0, 32'h00000080, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0010, 32'h0, 32'h80ADBEEF, 0));
    vecs.push_back(mk(1, 3'b001, 32'h0012, 32'h00001234, 32'h0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h0012, 32'h0, 32'h00001234, 0));
    vecs.push_back(mk(0, 3'b101, 32'h0010, 32'h0, 32'h0000BEEF, 0));
    vecs.push_back(mk(0, 3'b000, 32'h0011, 32'h0, 32'hFFFFFFBE, 0));
    vecs.push_back(mk(0, 3'b100, 32'h0012, 32'h0, 32'h00000034, 0));
    vecs.push_back(mk(0, 3'b010, 32'h1000, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'b011, 32'h0010, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h1000, 32'h11111111, 32'h0, 1));
    vecs.push_back(mk(1, 3'b100, 32'h0000, 32'h000000FF, 32'h0, 1));
    vecs.push_back(mk(1, 3'b101, 32'h0000, 32'h0000FFFF, 32'h0, 1));
    vecs.push_back(mk(0, 3'b010, 32'h0000, 32'h0, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(1, 3'b010, 32'h0020, 32'h55667788, 32'h0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h0011, 32'h0, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP));
    vecs.push_back(mk(0, 3'b010, 32'h0012, 32'h0, TRAP ? 32'h0 : 32'h1234BEEF, TRAP));
    vecs.push_back(mk(1, 3'b010, 32'h0014, 32'h00000000, 32'h0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h0015, 32'h0000ABCD, 32'h0, TRAP));
    vecs.push_back(mk(0, 3'b010, 32'h0014, 32'h0, TRAP ? 32'h0 : 32'h0000ABCD, 0));

    // Reset state
    repeat (3) @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", 32'(bus.req_ready), 32'd1);
    check("post-reset rsp_valid", 32'(bus.rsp_valid), 32'd0);

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Backpressure: response held for 5 cycles, a stray request in that window is ignored
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0010, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    while (!bus.rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", 32'(cyc), 32'(LAT));
    for (int k = 0; k < 5; k++) begin
      if (k == 1) drive_req(1'b1, 3'b010, 32'h0010, 32'hFFFFFFFF);
      if (k == 2) bus.req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("bp%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d rdata", k), bus.rsp_rdata, 32'h1234BEEF);
      check($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'd0);
    end
    $display("txn bp: LD held 5 cycles rdata=%08h", bus.rsp_rdata);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp rsp_valid cleared", 32'(bus.rsp_valid), 32'd0);
    run_txn(mk(0, 3'b010, 32'h0010, 32'h0, 32'h1234BEEF, 0), "bp-after");

    // Reset during WAIT of a store: memory keeps its previous contents
    @(negedge clk);
    drive_req(1'b1, 3'b010, 32'h0020, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst req_ready", 32'(bus.req_ready), 32'd0);
    check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    $display("txn midrst: ST 0x20 abandoned by reset");
    repeat (2) @(negedge clk);
    check("midrst rsp_valid idle", 32'(bus.rsp_valid), 32'd0);
    run_txn(mk(0, 3'b010, 32'h0020, 32'h0, 32'h55667788, 0), "midrst-after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
